// File: rtl/crypto_exec_unit.sv
// crypto_exec_unit: registered execute stage sharing one result path between a lane-wise ALU,
// a multiply/GF(2^8) unit, SHA-256 helper functions and an AES round/key-expansion unit.
module crypto_exec_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] A,
    input  logic [127:0] B,
    input  logic [127:0] C,
    input  logic [3:0]   aluOp,
    input  logic [3:0]   maluOp,
    input  logic [2:0]   shaOp,
    input  logic [1:0]   execSrc,
    input  logic         keyAssist,
    input  logic         encryption,
    input  logic         finalRound,
    input  logic [6:0]   wordSize,
    input  logic         wordMemW,
    input  logic [1:0]   set_type,
    output logic [127:0] execResult,
    output logic         branchTaken
);

    function automatic logic [127:0] lane_mask(input int unsigned lw);
        return (lw >= 128) ? '1 : ((128'd1 << lw) - 128'd1);
    endfunction

    // Lane-wise ALU; each lane is isolated by masking, so no carry crosses a lane boundary.
    function automatic logic [127:0] alu_lanes(input logic [3:0] op, input logic [127:0] a,
                                               input logic [127:0] b, input int unsigned lw);
        logic [127:0] m, la, lb, r, res;
        int unsigned  sh;
        m   = lane_mask(lw);
        sh  = 32'(b[6:0]) % lw;
        res = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i * lw < 128) begin
                la = (a >> (i * lw)) & m;
                lb = (b >> (i * lw)) & m;
                case (op)
                    4'd0:    r = la + lb;
                    4'd1:    r = la - lb;
                    4'd2:    r = la & lb;
                    4'd3:    r = la | lb;
                    4'd4:    r = la ^ lb;
                    4'd5:    r = ~la;
                    4'd6:    r = la << sh;
                    4'd7:    r = la >> sh;
                    4'd8:    r = (la << sh) | (la >> (lw - sh));
                    4'd9:    r = (la >> sh) | (la << (lw - sh));
                    4'd10:   r = lb;
                    4'd11:   r = la;
                    default: r = '0;
                endcase
                res = res | ((r & m) << (i * lw));
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mul_lanes(input logic [127:0] a, input logic [127:0] b,
                                               input int unsigned lw);
        logic [127:0] m, res;
        m   = lane_mask(lw);
        res = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i * lw < 128)
                res = res | (((((a >> (i * lw)) & m) * ((b >> (i * lw)) & m)) & m) << (i * lw));
        end
        return res;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sha_lane(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
        case (op)
            3'd0:    return rotr32(a, 2) ^ rotr32(a, 13) ^ rotr32(a, 22);
            3'd1:    return rotr32(a, 6) ^ rotr32(a, 11) ^ rotr32(a, 25);
            3'd2:    return rotr32(a, 7) ^ rotr32(a, 18) ^ (a >> 3);
            3'd3:    return rotr32(a, 17) ^ rotr32(a, 19) ^ (a >> 10);
            3'd4:    return (a & b) ^ (~a & c);
            3'd5:    return (a & b) ^ (a & c) ^ (b & c);
            default: return '0;
        endcase
    endfunction

    // Byte i lives at s[127-8i -: 8]; row r of column c is byte r+4c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int unsigned  src;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * src) -: 8];
            end
        end
        return o;
    endfunction

    // Circulant column multiply: {02,03,01,01} forward, {0e,0b,0d,09} inverse.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [31:0] k, o;
        logic [7:0]  acc;
        k = inv ? 32'h0e0b0d09 : 32'h02030101;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            acc = '0;
            for (int unsigned j = 0; j < 4; j++)
                acc = acc ^ gf_mul(k[31 - 8 * ((j + 4 - r) % 4) -: 8], col[31 - 8 * j -: 8]);
            o[31 - 8 * r -: 8] = acc;
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int unsigned c = 0; c < 4; c++)
            o[127 - 32 * c -: 32] = mix_col(s[127 - 32 * c -: 32], inv);
        return o;
    endfunction

    logic [127:0] alu_r, mul_r, malu_r, sha_r, aes_r, t_r, nxt_result;
    logic [31:0]  w0p, w1p, w2p, w3p;
    logic         nxt_branch;

    // Width select with constant lane widths so each lane layout is fixed hardware.
    always_comb begin
        alu_r = alu_lanes(aluOp, A, B, 128);
        mul_r = mul_lanes(A, B, 128);
        case (wordSize)
            7'd8:  begin alu_r = alu_lanes(aluOp, A, B, 8);  mul_r = mul_lanes(A, B, 8);  end
            7'd16: begin alu_r = alu_lanes(aluOp, A, B, 16); mul_r = mul_lanes(A, B, 16); end
            7'd32: begin alu_r = alu_lanes(aluOp, A, B, 32); mul_r = mul_lanes(A, B, 32); end
            7'd64: begin alu_r = alu_lanes(aluOp, A, B, 64); mul_r = mul_lanes(A, B, 64); end
            default: ;
        endcase
    end

    always_comb begin
        malu_r = '0;
        sha_r  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            case (maluOp)
                4'd0:    malu_r[8 * i +: 8] = mul_r[8 * i +: 8];
                4'd1:    malu_r[8 * i +: 8] = gf_mul(A[8 * i +: 8], B[8 * i +: 8]);
                4'd2:    malu_r[8 * i +: 8] = xtime(A[8 * i +: 8]);
                default: malu_r[8 * i +: 8] = 8'h00;
            endcase
        end
        for (int unsigned i = 0; i < 4; i++)
            sha_r[32 * i +: 32] = sha_lane(shaOp, A[32 * i +: 32], B[32 * i +: 32], C[32 * i +: 32]);
    end

    // AES: key-expansion chain, forward round, or inverse round (AddRoundKey before InvMixColumns).
    always_comb begin
        w0p = B[127:96] ^ A[31:0];
        w1p = B[95:64]  ^ w0p;
        w2p = B[63:32]  ^ w1p;
        w3p = B[31:0]   ^ w2p;
        t_r = '0;
        if (keyAssist) begin
            aes_r = {w0p, w1p, w2p, w3p};
        end else if (encryption) begin
            t_r   = shift_rows(A, 1'b0);
            aes_r = (finalRound ? t_r : mix_columns(t_r, 1'b0)) ^ B;
        end else begin
            t_r   = shift_rows(A, 1'b1) ^ B;
            aes_r = finalRound ? t_r : mix_columns(t_r, 1'b1);
        end
    end

    always_comb begin
        case (execSrc)
            2'd0:    nxt_result = alu_r;
            2'd1:    nxt_result = malu_r;
            2'd2:    nxt_result = sha_r;
            default: nxt_result = aes_r;
        endcase
        if (wordMemW) nxt_result = C;
        case (set_type)
            2'd0:    nxt_branch = (A[63:0] == B[63:0]);
            2'd1:    nxt_branch = (A[63:0] != B[63:0]);
            2'd2:    nxt_branch = (A[63:0] <  B[63:0]);
            default: nxt_branch = (A[63:0] >= B[63:0]);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            execResult  <= '0;
            branchTaken <= 1'b0;
        end else begin
            execResult  <= nxt_result;
            branchTaken <= nxt_branch;
        end
    end

endmodule

// File: tb/tb_crypto_exec_unit.sv
// Directed self-checking bench for crypto_exec_unit with hand-computed expected values.
module tb_crypto_exec_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] A, B, C;
    logic [3:0]   aluOp, maluOp;
    logic [2:0]   shaOp;
    logic [1:0]   execSrc, set_type;
    logic         keyAssist, encryption, finalRound, wordMemW;
    logic [6:0]   wordSize;
    logic [127:0] execResult;
    logic         branchTaken;

    int total = 0;
    int bad   = 0;

    crypto_exec_unit dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .C(C),
        .aluOp(aluOp), .maluOp(maluOp), .shaOp(shaOp), .execSrc(execSrc),
        .keyAssist(keyAssist), .encryption(encryption), .finalRound(finalRound),
        .wordSize(wordSize), .wordMemW(wordMemW), .set_type(set_type),
        .execResult(execResult), .branchTaken(branchTaken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; A = '0; B = '0; C = '0;
        aluOp = '0; maluOp = '0; shaOp = '0; execSrc = '0; set_type = '0;
        keyAssist = 1'b0; encryption = 1'b0; finalRound = 1'b0; wordMemW = 1'b0;
        wordSize = 7'd8;
        #2 reset = 1'b1;
        #1;
        chk("rst_result", execResult, '0);
        chk("rst_branch", 128'(branchTaken), 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ALU
        execSrc = 2'd0; aluOp = 4'd0;
        wordSize = 7'd16; A = {8{16'h00FF}}; B = {8{16'h0001}}; cyc();
        chk("alu_add16", execResult, {8{16'h0100}});
        wordSize = 7'd8; A = {16{8'hFF}}; B = {16{8'h01}}; cyc();
        chk("alu_add8_isolation", execResult, '0);
        aluOp = 4'd11; A = {4{32'h12345678}}; cyc();
        chk("alu_passA", execResult, {4{32'h12345678}});
        aluOp = 4'd0; wordSize = 7'd127; A = '1; B = 128'd1; cyc();
        chk("alu_add128", execResult, '0);
        aluOp = 4'd1; wordSize = 7'd32; A = '0; B = {4{32'd1}}; cyc();
        chk("alu_sub32", execResult, {4{32'hFFFFFFFF}});
        wordSize = 7'd5; cyc();
        chk("alu_sub_wide", execResult, 128'hFFFFFFFE_FFFFFFFE_FFFFFFFE_FFFFFFFF);
        wordSize = 7'd16; A = {8{16'h8001}}; B = 128'd1;
        aluOp = 4'd6; cyc(); chk("alu_shl16", execResult, {8{16'h0002}});
        aluOp = 4'd8; cyc(); chk("alu_rotl16", execResult, {8{16'h0003}});
        aluOp = 4'd9; B = 128'd17; cyc(); chk("alu_rotr16_mod", execResult, {8{16'hC000}});
        aluOp = 4'd7; wordSize = 7'd8; A = {16{8'h80}}; B = 128'd15; cyc();
        chk("alu_shr8_mod", execResult, {16{8'h01}});
        A = {4{32'hF0F0F0F0}}; B = {4{32'hFF00FF00}};
        aluOp = 4'd4; cyc(); chk("alu_xor", execResult, {4{32'h0FF00FF0}});
        aluOp = 4'd2; cyc(); chk("alu_and", execResult, {4{32'hF000F000}});
        aluOp = 4'd5; cyc(); chk("alu_notA", execResult, {4{32'h0F0F0F0F}});
        aluOp = 4'd10; cyc(); chk("alu_passB", execResult, {4{32'hFF00FF00}});
        aluOp = 4'd12; cyc(); chk("alu_undef", execResult, '0);

        // MALU
        execSrc = 2'd1; maluOp = 4'd0;
        wordSize = 7'd8; A = {16{8'h10}}; B = {16{8'h11}}; cyc();
        chk("malu_mul8", execResult, {16{8'h10}});
        wordSize = 7'd16; A = {8{16'h0010}}; B = {8{16'h0011}}; cyc();
        chk("malu_mul16", execResult, {8{16'h0110}});
        maluOp = 4'd1; A = {16{8'h57}}; B = {16{8'h83}}; cyc();
        chk("malu_gfmul", execResult, {16{8'hC1}});
        maluOp = 4'd2; cyc(); chk("malu_xtime", execResult, {16{8'hAE}});
        maluOp = 4'd3; cyc(); chk("malu_undef", execResult, '0);

        // SHA helpers on single-bit lanes
        execSrc = 2'd2; A = {4{32'd1}};
        shaOp = 3'd0; cyc(); chk("sha_S0", execResult, {4{32'h40080400}});
        shaOp = 3'd1; cyc(); chk("sha_S1", execResult, {4{32'h04200080}});
        shaOp = 3'd2; cyc(); chk("sha_s0", execResult, {4{32'h02004000}});
        shaOp = 3'd3; cyc(); chk("sha_s1", execResult, {4{32'h0000A000}});
        shaOp = 3'd4; A = '1; B = 128'h0123456789ABCDEF_FEDCBA9876543210;
        C = 128'hA5A5A5A5_5A5A5A5A_3C3C3C3C_C3C3C3C3; cyc();
        chk("sha_ch_ones", execResult, 128'h0123456789ABCDEF_FEDCBA9876543210);
        A = '0; cyc(); chk("sha_ch_zero", execResult, 128'hA5A5A5A5_5A5A5A5A_3C3C3C3C_C3C3C3C3);
        shaOp = 3'd5; A = B; cyc();
        chk("sha_maj", execResult, 128'h0123456789ABCDEF_FEDCBA9876543210);
        shaOp = 3'd6; cyc(); chk("sha_undef", execResult, '0);

        // AES
        execSrc = 2'd3; keyAssist = 1'b0; encryption = 1'b1; finalRound = 1'b0;
        A = 128'hdb000000_00130000_00005300_00000045; B = '0; cyc();
        chk("aes_mixcol", execResult, 128'h8e4da1bc_00000000_00000000_00000000);
        finalRound = 1'b1; cyc();
        chk("aes_enc_final", execResult, 128'hdb135345_00000000_00000000_00000000);
        encryption = 1'b0; A = 128'h00010203_04050607_08090a0b_0c0d0e0f; cyc();
        chk("aes_dec_final", execResult, 128'h000d0a07_04010e0b_0805020f_0c090603);
        // Identical columns make the state invariant under (Inv)ShiftRows.
        encryption = 1'b1; finalRound = 1'b0;
        A = {4{32'hdb135345}}; B = {4{32'h01020304}}; cyc();
        chk("aes_enc_round", execResult, {4{32'h8f4fa2b8}});
        encryption = 1'b0; A = execResult; cyc();
        chk("aes_roundtrip", execResult, {4{32'hdb135345}});
        keyAssist = 1'b1; A = 128'h8b84eb01; B = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c; cyc();
        chk("aes_keyexp", execResult, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);

        // Branch
        execSrc = 2'd0; aluOp = 4'd0; keyAssist = 1'b0;
        A = 128'd5; B = 128'd7;
        set_type = 2'd2; cyc(); chk("br_ltu", 128'(branchTaken), 128'd1);
        set_type = 2'd0; cyc(); chk("br_eq", 128'(branchTaken), 128'd0);
        set_type = 2'd3; cyc(); chk("br_geu", 128'(branchTaken), 128'd0);
        set_type = 2'd1; cyc(); chk("br_ne", 128'(branchTaken), 128'd1);
        set_type = 2'd0; A = {64'hFFFF_0000_FFFF_0000, 64'd9}; B = 128'd9; cyc();
        chk("br_eq_low64", 128'(branchTaken), 128'd1);
        A = 128'hFFFF_FFFF_FFFF_FFFF; B = 128'd1;
        set_type = 2'd2; cyc(); chk("br_ltu_unsigned", 128'(branchTaken), 128'd0);
        set_type = 2'd3; cyc(); chk("br_geu_unsigned", 128'(branchTaken), 128'd1);

        // Store pass-through overrides the AES select
        execSrc = 2'd3; keyAssist = 1'b1; wordMemW = 1'b1;
        A = 128'd5; B = 128'd7; set_type = 2'd2;
        C = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF; cyc();
        chk("store_C", execResult, 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF);
        chk("store_branch", 128'(branchTaken), 128'd1);

        // Reset mid-stream clears outputs without a clock edge
        reset = 1'b1;
        #1;
        chk("midrst_result", execResult, '0);
        chk("midrst_branch", 128'(branchTaken), 128'd0);
        #2 reset = 1'b0;
        wordMemW = 1'b0; execSrc = 2'd0; aluOp = 4'd11; cyc();
        chk("post_rst_result", execResult, 128'd5);
        chk("post_rst_branch", 128'(branchTaken), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
